lfsr_encrypt_sequencer: RTL and testbench
=========================================

// Module: lfsr_encrypt_sequencer
// PURPOSE
//  Hardware sequencer for the Program #1 encryption task. On request it reads the config
//  words from data memory (pre_length@61, tap pattern@62, LFSR seed@63), then emits the
//  64-byte encrypted message to DM[64..127]: padded/biased char XOR 7-bit LFSR, MSB=0.
//  Sits beside top_level's DM as a single-port master; req/ack match the top-level handshake.
// PARAMETERS
//  ADDR_W    8   data memory address width
//  DATA_W    8   data memory word width
//  MSG_MAX   54  max message length; source bytes read from DM[0..MSG_MAX-1]
//  OUT_BASE  64  first output address
//  OUT_LEN   64  number of output bytes
//  CFG_PRE   61  address of pre_length
//  CFG_TAP   62  address of LFSR tap pattern
//  CFG_INIT  63  address of LFSR starting state
// PORTS
//  clk          in   1       clock, all state on rising edge
//  init         in   1       synchronous active-high reset
//  req          in   1       1 = hold idle; 0 = run program
//  ack          out  1       program done flag (registered)
//  dm_addr      out  ADDR_W  data memory address
//  dm_wr_en     out  1       data memory write strobe
//  dm_wr_data   out  DATA_W  data memory write data
//  dm_rd_data   in   DATA_W  DM read data, valid the cycle AFTER dm_addr presented
// BEHAVIOUR
//  Reset (init=1 at edge): state=IDLE, ack=0, dm_addr=0, dm_wr_en=0, dm_wr_data=0, i=0,
//   lfsr=0. Reset mid-run abandons the run; no write occurs in the cycle after reset.
//  Memory outputs are Moore (decoded from state/regs); dm_wr_en=0 in all states except WR.
//  FSM: IDLE -> LD_PRE -> LD_TAP -> LD_INIT -> CAP -> {RD -> WR} x OUT_LEN -> DONE.
//   IDLE:    req=0 sampled -> LD_PRE; req=1 stays.
//   LD_PRE:  dm_addr=CFG_PRE.  LD_TAP: addr=CFG_TAP, capture pre_len<=dm_rd_data.
//   LD_INIT: addr=CFG_INIT, capture taps<=dm_rd_data[6:0].
//   CAP:     capture lfsr<=dm_rd_data[6:0] (bit7 of seed ignored; 0 is NOT substituted), i=0.
//   RD:      m=i-pre_len (9-bit signed); in_rng=(i>=pre_len)&&(m<MSG_MAX), registered.
//            in_rng: dm_addr=m[5:0]; else dm_addr=0 and the read result is discarded.
//   WR:      dm_addr=OUT_BASE+i, dm_wr_en=1,
//            dm_wr_data={1'b0, ((in_rng ? dm_rd_data : 8'h00) ^ {1'b0,lfsr})[6:0]};
//            then lfsr<={lfsr[5:0], ^(lfsr & taps)}, i<=i+1; i==OUT_LEN-1 -> DONE else RD.
//   DONE:    ack=1; req=0 holds DONE (no rerun); req=1 -> IDLE with ack=0 next cycle.
//  req ignored in LD_*/CAP/RD/WR (run always completes unless reset).
//  Latency: req sampled low at edge E0 -> first write at E5..E6 (WR state), ack=1 from E132.
//  Padding byte (i outside message) encrypts 0x00 (space-0x20); out-of-range m never read,
//   so max source address = MSG_MAX-1 regardless of pre_len (pre_len any 8-bit value).
//  i is 6-bit counter; no wrap: DONE entered exactly after 64th write. Exactly 64 writes/run.
// TESTING
//  1. pre=10, taps=0x60, seed=0x01, DM[0..53]=0 -> DM[64..70]=01,02,04,08,10,20,41; ack@E132.
//  2. seed=0x00, "Mr. Watson..." biased, pre=12 -> DM[76+k]=DM[k] for k<41, rest 0x00.
//  3. pre=26, taps=0x7B -> no read addr >=38; DM[64+j] matches bench model for all j, MSB=0.
//  4. init pulsed at cycle 50 mid-run -> next cycle wr_en=0, ack=0, IDLE; rerun scores 64/64.
//  5. req held 0 after ack -> ack stays 1, no writes; req=1 -> ack=0; req=0 -> full rerun.
//  6. All 9 tap patterns x random seed/pre(10..26) vs bench LFSR model -> 64/64 each.

Source files
------------

// File: rtl/lfsr_encrypt_sequencer_if.sv
// Program/data-memory bundle between the encryption sequencer (master) and the
// controller plus single-port data memory that sit around it (slave).
interface lfsr_encrypt_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // req low asks for a run; ack rises when the 64th byte is written and
    // stays high until req returns high; dm_rd_data answers dm_addr one cycle late.
    logic              req;
    logic              ack;
    logic [ADDR_W-1:0] dm_addr;
    logic              dm_wr_en;
    logic [DATA_W-1:0] dm_wr_data;
    logic [DATA_W-1:0] dm_rd_data;
    logic [2:0]        dbg_state;

    modport master (
        input  req, dm_rd_data,
        output ack, dm_addr, dm_wr_en, dm_wr_data, dbg_state
    );

    modport slave (
        output req, dm_rd_data,
        input  ack, dm_addr, dm_wr_en, dm_wr_data, dbg_state
    );
endinterface

// File: rtl/lfsr_encrypt_sequencer.sv
// Reads pre_length/taps/seed from data memory, then writes the 64-byte
// LFSR-encrypted message to DM[64..127] and raises ack.
module lfsr_encrypt_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MSG_MAX  = 54,
    parameter int OUT_BASE = 64,
    parameter int OUT_LEN  = 64,
    parameter int CFG_PRE  = 61,
    parameter int CFG_TAP  = 62,
    parameter int CFG_INIT = 63
) (
    input  logic                      clk,
    input  logic                      init,
    lfsr_encrypt_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_PRE  = 3'd1,
        S_LD_TAP  = 3'd2,
        S_LD_INIT = 3'd3,
        S_CAP     = 3'd4,
        S_RD      = 3'd5,
        S_WR      = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t      state;
    logic        ack;
    logic [5:0]  i;
    logic [6:0]  lfsr;
    logic [6:0]  taps;
    logic [7:0]  pre_len;
    logic        in_rng;

    logic [5:0]  m_lo;
    logic [6:0]  src7;

    // Source index i-pre_len, evaluated in 9-bit signed space so a large
    // pre_len never aliases back into the message window.
    function automatic logic range_ok(input logic [5:0] idx, input logic [7:0] pre);
        logic [8:0] m;
        m = {3'b000, idx} - {1'b0, pre};
        return ({2'b00, idx} >= pre) && (m < 9'(MSG_MAX));
    endfunction

    always_ff @(posedge clk) begin
        if (init) begin
            state   <= S_IDLE;
            ack     <= 1'b0;
            i       <= '0;
            lfsr    <= '0;
            taps    <= '0;
            pre_len <= '0;
            in_rng  <= 1'b0;
        end else begin
            case (state)
                S_IDLE:    if (!bus.req) state <= S_LD_PRE;
                S_LD_PRE:  state <= S_LD_TAP;
                S_LD_TAP: begin
                    pre_len <= bus.dm_rd_data[7:0];
                    state   <= S_LD_INIT;
                end
                S_LD_INIT: begin
                    taps  <= bus.dm_rd_data[6:0];
                    state <= S_CAP;
                end
                S_CAP: begin
                    lfsr   <= bus.dm_rd_data[6:0];
                    i      <= '0;
                    in_rng <= range_ok(6'd0, pre_len);
                    state  <= S_RD;
                end
                S_RD:      state <= S_WR;
                S_WR: begin
                    lfsr   <= {lfsr[5:0], ^(lfsr & taps)};
                    i      <= i + 6'd1;
                    in_rng <= range_ok(i + 6'd1, pre_len);
                    if (i == 6'(OUT_LEN - 1)) begin
                        state <= S_DONE;
                        ack   <= 1'b1;
                    end else begin
                        state <= S_RD;
                    end
                end
                S_DONE: begin
                    if (bus.req) begin
                        state <= S_IDLE;
                        ack   <= 1'b0;
                    end
                end
                default:   state <= S_IDLE;
            endcase
        end
    end

    assign m_lo = i - pre_len[5:0];
    assign src7 = in_rng ? bus.dm_rd_data[6:0] : 7'd0;

    always_comb begin
        bus.dm_addr    = '0;
        bus.dm_wr_en   = 1'b0;
        bus.dm_wr_data = '0;
        case (state)
            S_LD_PRE:  bus.dm_addr = ADDR_W'(CFG_PRE);
            S_LD_TAP:  bus.dm_addr = ADDR_W'(CFG_TAP);
            S_LD_INIT: bus.dm_addr = ADDR_W'(CFG_INIT);
            S_RD:      if (in_rng) bus.dm_addr = ADDR_W'(m_lo);
            S_WR: begin
                bus.dm_addr    = ADDR_W'(OUT_BASE) + ADDR_W'(i);
                bus.dm_wr_en   = 1'b1;
                bus.dm_wr_data = DATA_W'({1'b0, src7 ^ lfsr});
            end
            default: ;
        endcase
    end

    assign bus.ack       = ack;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_lfsr_encrypt_sequencer.sv
// Directed bench for lfsr_encrypt_sequencer: data memory model, byte-level
// encryption model, per-write scoreboard and end-of-run memory checks.
module tb_lfsr_encrypt_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DONE = 3'd7;

    logic clk = 1'b0;
    logic init;
    always #5 clk = ~clk;

    lfsr_encrypt_sequencer_if bus ();

    lfsr_encrypt_sequencer dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    // Memory: bench-loaded lower half, DUT-written upper half.
    logic [7:0] src_mem [0:63];
    logic [7:0] out_mem [64:127];

    always @(posedge clk) begin
        if (bus.dm_wr_en && bus.dm_addr >= 8'd64 && bus.dm_addr <= 8'd127)
            out_mem[bus.dm_addr] <= bus.dm_wr_data;
        if (bus.dm_addr >= 8'd64 && bus.dm_addr <= 8'd127)
            bus.dm_rd_data <= out_mem[bus.dm_addr];
        else if (bus.dm_addr < 8'd64)
            bus.dm_rd_data <= src_mem[bus.dm_addr[5:0]];
        else
            bus.dm_rd_data <= 8'h00;
    end

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int max_rd = 0;
    logic [15:0] exp_q [$];
    logic [7:0]  model_out [0:63];
    logic [7:0]  t1_exp [0:6];
    logic [7:0]  tap_list [0:8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every write must match the next expected {addr,data}.
    always @(negedge clk) begin
        if (!init) begin
            if (bus.dm_wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(bus.dm_addr), 32'hFFFF);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.dm_addr), 32'(e[15:8]));
                    check("wr_data", 32'(bus.dm_wr_data), 32'(e[7:0]));
                end
            end else if (bus.dm_addr < 8'd61) begin
                if (int'(bus.dm_addr) > max_rd) max_rd = int'(bus.dm_addr);
            end
        end
    end

    // Encryption model straight from the byte rules: pad/message char XOR 7-bit LFSR.
    task automatic build_expect(input int pre, input int taps, input int seed);
        int lf, ch, fb;
        lf = seed & 8'h7f;
        exp_q.delete();
        for (int k = 0; k < 64; k++) begin
            if (k >= pre && (k - pre) < 54) ch = int'(src_mem[k - pre]);
            else ch = 0;
            model_out[k] = 8'((ch ^ lf) & 8'h7f);
            exp_q.push_back({8'(64 + k), model_out[k]});
            fb = 0;
            for (int b = 0; b < 7; b++) fb = fb ^ (((lf & taps) >> b) & 1);
            lf = ((lf << 1) | fb) & 8'h7f;
        end
    endtask

    task automatic load_cfg(input int pre, input int taps, input int seed);
        src_mem[61] = 8'(pre);
        src_mem[62] = 8'(taps);
        src_mem[63] = 8'(seed);
        build_expect(pre, taps, seed);
    endtask

    task automatic run_program(input int pre, input int taps, input int seed, input bit hold_done);
        int cyc, wr0, exp_max;
        bit got;
        load_cfg(pre, taps, seed);
        @(posedge clk); #2;
        wr0 = wr_cnt;
        max_rd = 0;
        bus.req = 1'b0;
        cyc = 0;
        got = 0;
        while (cyc < 300 && !got) begin
            @(posedge clk); #2;
            cyc++;
            if (bus.ack) got = 1;
        end
        check("ack_seen", 32'(got), 32'd1);
        check("ack_latency", 32'(cyc - 1), 32'd132);
        check("write_count", 32'(wr_cnt - wr0), 32'd64);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_max = (63 - pre < 53) ? 63 - pre : 53;
        check("max_src_addr", 32'(max_rd), 32'(exp_max));
        for (int j = 0; j < 64; j++)
            check("dm_out", 32'(out_mem[64 + j]), 32'(model_out[j]));
        if (!hold_done) begin
            bus.req = 1'b1;
            @(posedge clk); #2;
            check("ack_release", 32'(bus.ack), 32'd0);
            check("idle_after_release", 32'(bus.dbg_state), 32'(ST_IDLE));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        string msg;
        int wr_snap;

        for (int k = 0; k < 64; k++) src_mem[k] = 8'h00;
        t1_exp[0] = 8'h01; t1_exp[1] = 8'h02; t1_exp[2] = 8'h04; t1_exp[3] = 8'h08;
        t1_exp[4] = 8'h10; t1_exp[5] = 8'h20; t1_exp[6] = 8'h41;
        tap_list[0] = 8'h60; tap_list[1] = 8'h48; tap_list[2] = 8'h78;
        tap_list[3] = 8'h72; tap_list[4] = 8'h6A; tap_list[5] = 8'h69;
        tap_list[6] = 8'h5C; tap_list[7] = 8'h7E; tap_list[8] = 8'h7B;

        // Reset state
        init = 1'b1;
        bus.req = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_wr_en", 32'(bus.dm_wr_en), 32'd0);
        check("rst_addr", 32'(bus.dm_addr), 32'd0);
        check("rst_wr_data", 32'(bus.dm_wr_data), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        init = 1'b0;
        @(posedge clk); #2;
        check("idle_hold_req1", 32'(bus.dbg_state), 32'(ST_IDLE));

        // 1: zero message, taps 0x60, seed 1
        run_program(10, 8'h60, 8'h01, 1'b0);
        for (int j = 0; j < 7; j++) begin
            check("t1_model_pin", 32'(model_out[j]), 32'(t1_exp[j]));
            check("t1_dm_pin", 32'(out_mem[64 + j]), 32'(t1_exp[j]));
        end

        // 2: seed 0 leaves the biased message in clear
        msg = "Mr. Watson, come here. I want to see you.";
        for (int k = 0; k < 54; k++)
            src_mem[k] = (k < msg.len()) ? 8'(msg[k]) - 8'h20 : 8'h00;
        run_program(12, 8'h60, 8'h00, 1'b0);
        check("t2_pad_first", 32'(out_mem[64]), 32'h00);
        check("t2_first_char", 32'(out_mem[76]), 32'h2D);
        check("t2_last_char", 32'(out_mem[116]), 32'h0E);
        check("t2_tail_zero", 32'(out_mem[117]), 32'h00);

        // 3: large pre_len keeps reads below 38; seed bit7 must be ignored
        for (int k = 0; k < 54; k++) src_mem[k] = 8'($urandom_range(0, 255));
        run_program(26, 8'h7B, 8'hD3, 1'b0);
        check("t3_max_read", 32'(max_rd), 32'd37);

        // 4: reset mid-run, then a clean rerun
        load_cfg(20, 8'h78, 8'h55);
        @(posedge clk); #2;
        bus.req = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        bus.req = 1'b1;
        init = 1'b1;
        @(posedge clk); #2;
        check("t4_wr_en", 32'(bus.dm_wr_en), 32'd0);
        check("t4_ack", 32'(bus.ack), 32'd0);
        check("t4_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        check("t4_addr", 32'(bus.dm_addr), 32'd0);
        init = 1'b0;
        exp_q.delete();
        @(posedge clk); #2;
        check("t4_stay_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
        run_program(20, 8'h78, 8'h55, 1'b0);

        // 5: req held low after done -> no rerun
        run_program(15, 8'h69, 8'h2A, 1'b1);
        wr_snap = wr_cnt;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #2;
            check("t5_ack_hold", 32'(bus.ack), 32'd1);
            check("t5_state_done", 32'(bus.dbg_state), 32'(ST_DONE));
        end
        check("t5_no_writes", 32'(wr_cnt - wr_snap), 32'd0);
        bus.req = 1'b1;
        @(posedge clk); #2;
        check("t5_ack_drop", 32'(bus.ack), 32'd0);
        run_program(15, 8'h69, 8'h2A, 1'b0);

        // 6: every tap pattern with random seed, pre and message
        for (int t = 0; t < 9; t++) begin
            for (int k = 0; k < 54; k++) src_mem[k] = 8'($urandom_range(0, 255));
            run_program($urandom_range(10, 26), int'(tap_list[t]), $urandom_range(0, 255), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
